prog_fetch_ctrl: RTL and testbench

//  Instruction-fetch front end for the dual-issue core; the requesting side of the

---
 rtl/prog_fetch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_prog_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// prog_fetch_ctrl
// Instruction-fetch front end for the dual-issue core. It holds the halfword
// PC, drives the dual-bank program ROM (row address, odd-PC bit, bank-mux
// selects) and registers the returned instruction pair into a 2-slot fetch
// buffer. Decode consumes 0/1/2 slots per cycle; branches redirect the PC.
//
// Optional feature macro: BR_ZERO_BUBBLE_EN
//   defined   : a branch in RUN drives the fetch PC to br_target in the same
//               cycle, so the target pair is loaded at the next edge with no
//               bubble.
//   undefined : a branch costs one bubble cycle (FLUSH). The fetch PC never
//               sees br_target, which keeps the ROM address path short.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rom_addr  [PC_W-2:0]  ROM row address (fpc[PC_W-1:1])
//   pc_1                  ROM odd-PC bit (fpc[0])
//   sel_mem_1             IR_1 bank select: 1 = bank1 (even fpc), 0 = bank0
//   sel_mem_0 [1:0]       IR_0 bank select: 0 = bank0 (even fpc), 2 = bank1
//   rom_ir0/rom_ir1       ROM instruction at fpc / fpc+1
//   stall                 decode stall: hold buffer and PC
//   consume   [1:0]       slots taken by decode this cycle (3 acts as 2)
//   br_valid/br_target    branch redirect request and halfword target
//   ir0/ir1               buffered instructions at pc / pc+1 (registered)
//   ir0_valid/ir1_valid   slot valid flags (registered)
//   pc                    halfword address of ir0 (registered)
// ---------------------------------------------------------------------------
module prog_fetch_ctrl #(
    parameter int              PC_W   = 15,
    parameter logic [PC_W-1:0] RST_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-2:0] rom_addr,
    output logic            pc_1,
    output logic            sel_mem_1,
    output logic [1:0]      sel_mem_0,
    input  logic [15:0]     rom_ir0,
    input  logic [15:0]     rom_ir1,
    input  logic            stall,
    input  logic [1:0]      consume,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    output logic [15:0]     ir0,
    output logic [15:0]     ir1,
    output logic            ir0_valid,
    output logic            ir1_valid,
    output logic [PC_W-1:0] pc
);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir0_q, ir0_d;
    logic [15:0]     ir1_q, ir1_d;
    logic            ir0_valid_q, ir0_valid_d;
    logic            ir1_valid_q, ir1_valid_d;

    logic [PC_W-1:0] fpc_s;
    logic            load_s;
    logic            redirect_s;
    logic [1:0]      adv_s;

    // Saturate consume: a request for 3 slots advances by only 2.
    always_comb begin
        if (consume == 2'd3) begin
            adv_s = 2'd2;
        end else begin
            adv_s = consume;
        end
    end

    // Fetch PC selection, next-state and buffer-load decision.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir0_d       = ir0_q;
        ir1_d       = ir1_q;
        ir0_valid_d = ir0_valid_q;
        ir1_valid_d = ir1_valid_q;
        fpc_s       = pc_q;
        load_s      = 1'b0;
        redirect_s  = 1'b0;

        case (state_q)
            ST_FILL, ST_FLUSH: begin
                if (br_valid) begin
                    redirect_s = 1'b1;
                end else begin
                    load_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (br_valid) begin
                    redirect_s = 1'b1;
                end else if (stall) begin
                    load_s = 1'b0;
                end else begin
                    fpc_s  = pc_q + {{(PC_W-2){1'b0}}, adv_s};
                    load_s = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: recover by refilling from the held PC.
                state_d = ST_FILL;
            end
        endcase

`ifdef BR_ZERO_BUBBLE_EN
        // The target pair is fetched in the same cycle as the redirect.
        if (redirect_s) begin
            fpc_s  = br_target;
            load_s = 1'b1;
        end else begin
            fpc_s = fpc_s;
        end
`else
        // Redirect parks in FLUSH with an empty buffer; the consumed slots
        // and the held instructions are discarded by clearing the valids.
        if (redirect_s) begin
            pc_d        = br_target;
            ir0_valid_d = 1'b0;
            ir1_valid_d = 1'b0;
            state_d     = ST_FLUSH;
        end else begin
            pc_d = pc_d;
        end
`endif

        if (load_s) begin
            pc_d        = fpc_s;
            ir0_d       = rom_ir0;
            ir1_d       = rom_ir1;
            ir0_valid_d = 1'b1;
            ir1_valid_d = 1'b1;
            state_d     = ST_RUN;
        end else begin
            ir0_d = ir0_d;
        end
    end

    // ROM request: row address, odd bit and bank-mux selects from fpc.
    // The code 1 on sel_mem_0 is reserved and never produced.
    always_comb begin
        rom_addr = fpc_s[PC_W-1:1];
        pc_1     = fpc_s[0];
        if (fpc_s[0]) begin
            sel_mem_0 = 2'd2;
            sel_mem_1 = 1'b0;
        end else begin
            sel_mem_0 = 2'd0;
            sel_mem_1 = 1'b1;
        end
    end

    // State, PC and fetch-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            pc_q        <= RST_PC;
            ir0_q       <= 16'h0000;
            ir1_q       <= 16'h0000;
            ir0_valid_q <= 1'b0;
            ir1_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir0_q       <= ir0_d;
            ir1_q       <= ir1_d;
            ir0_valid_q <= ir0_valid_d;
            ir1_valid_q <= ir1_valid_d;
        end
    end

    assign ir0       = ir0_q;
    assign ir1       = ir1_q;
    assign ir0_valid = ir0_valid_q;
    assign ir1_valid = ir1_valid_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
module tb_prog_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] rom_addr;
    logic        pc_1;
    logic        sel_mem_1;
    logic [1:0]  sel_mem_0;
    logic [15:0] rom_ir0;
    logic [15:0] rom_ir1;
    logic        stall = 1'b0;
    logic [1:0]  consume = 2'd0;
    logic        br_valid = 1'b0;
    logic [14:0] br_target = 15'd0;
    logic [15:0] ir0, ir1;
    logic        ir0_valid, ir1_valid;
    logic [14:0] pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .pc_1(pc_1),
        .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0),
        .rom_ir0(rom_ir0), .rom_ir1(rom_ir1), .stall(stall),
        .consume(consume), .br_valid(br_valid), .br_target(br_target),
        .ir0(ir0), .ir1(ir1), .ir0_valid(ir0_valid), .ir1_valid(ir1_valid),
        .pc(pc)
    );

    // Program image by halfword address; banks: bank0 = even, bank1 = odd.
    logic [15:0] mem [0:32767];
    logic [13:0] b0_row;
    logic [15:0] b0_data, b1_data;

    assign b0_row  = rom_addr + {13'd0, pc_1};
    assign b0_data = mem[{b0_row, 1'b0}];
    assign b1_data = mem[{rom_addr, 1'b1}];
    assign rom_ir0 = (sel_mem_0 == 2'd0) ? b0_data :
                     (sel_mem_0 == 2'd2) ? b1_data : 16'hDEAD;
    assign rom_ir1 = sel_mem_1 ? b1_data : b0_data;

    // Behavioural model: buffer contents follow directly from pc.
    logic [14:0] m_pc;
    logic        m_v;
    logic        m_loading;
    logic [15:0] m_ir0, m_ir1;

    function automatic logic [14:0] exp_fpc();
        logic [14:0] f;
        int          adv;
        adv = (consume > 2'd2) ? 2 : int'(consume);
`ifdef BR_ZERO_BUBBLE_EN
        if (br_valid) f = br_target;
`else
        if (br_valid) f = m_pc;
`endif
        else if (m_loading) f = m_pc;
        else if (stall) f = m_pc;
        else f = 15'((int'(m_pc) + adv) % 32768);
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [14:0] f;
        if (!rst_n) begin
            m_pc = 15'd0; m_v = 1'b0; m_loading = 1'b1;
            m_ir0 = 16'h0000; m_ir1 = 16'h0000;
        end else begin
            f = exp_fpc();
`ifdef BR_ZERO_BUBBLE_EN
            if (1'b0) begin
`else
            if (br_valid) begin
`endif
                m_pc = br_target; m_v = 1'b0; m_loading = 1'b1;
            end else if (!m_loading && stall && !br_valid) begin
                m_pc = m_pc;
            end else begin
                m_pc = f; m_v = 1'b1; m_loading = 1'b0;
                m_ir0 = mem[f]; m_ir1 = mem[15'(f + 15'd1)];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        logic [14:0] f;
        f = exp_fpc();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("ir0_valid", 32'(ir0_valid), 32'(m_v));
        chk("ir1_valid", 32'(ir1_valid), 32'(m_v));
        if (m_v || !rst_n) begin
            chk("ir0", 32'(ir0), 32'(m_ir0));
            chk("ir1", 32'(ir1), 32'(m_ir1));
        end
        chk("rom_addr", 32'(rom_addr), 32'(f[14:1]));
        chk("pc_1", 32'(pc_1), 32'(f[0]));
        chk("sel_mem_0", 32'(sel_mem_0), f[0] ? 32'd2 : 32'd0);
        chk("sel_mem_1", 32'(sel_mem_1), f[0] ? 32'd0 : 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!ir0_valid && k < 4) begin
            tick();
            k++;
        end
        chk(name, 32'(ir0_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'((i * 37 + 16'h4000) % 65536);
        mem[0] = 16'h2000; mem[1] = 16'h2112; mem[2] = 16'h0209;
        mem[3] = 16'h2334; mem[4] = 16'h2256; mem[5] = 16'h0212;
        mem[15'h13] = 16'h7407; mem[15'h14] = 16'h7B01;
        mem[15'h7FFF] = 16'h1234;

        tick(); tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_valid", 32'(ir0_valid), 32'h0);
        chk("rst_ir0", 32'(ir0), 32'h0);
        rst_n = 1'b1;

        // 1: first fill
        tick();
        chk("t1_pc", 32'(pc), 32'h0);
        chk("t1_ir0", 32'(ir0), 32'h2000);
        chk("t1_ir1", 32'(ir1), 32'h2112);
        chk("t1_v1", 32'(ir1_valid), 32'h1);

        // 2: consume 2 per cycle
        consume = 2'd2;
        tick(); chk("t2_pc2", 32'(pc), 32'h2);
        tick(); consume = 2'd0;
        chk("t2_pc4", 32'(pc), 32'h4);
        chk("t2_ir0", 32'(ir0), 32'h2256);
        chk("t2_ir1", 32'(ir1), 32'h0212);

        // 3: back to 0, then consume 1 -> odd fetch
        br_target = 15'h0; br_valid = 1'b1;
        tick(); br_valid = 1'b0;
        wait_valid("t3_land");
        chk("t3_pc0", 32'(pc), 32'h0);
        consume = 2'd1; #1;
        chk("t3_rom_addr", 32'(rom_addr), 32'h0);
        chk("t3_pc_1", 32'(pc_1), 32'h1);
        chk("t3_sel0", 32'(sel_mem_0), 32'h2);
        chk("t3_sel1", 32'(sel_mem_1), 32'h0);
        tick(); consume = 2'd0; #1;
        chk("t3_pc", 32'(pc), 32'h1);
        chk("t3_ir0", 32'(ir0), 32'h2112);
        chk("t3_ir1", 32'(ir1), 32'h0209);

        // 4: stall with consume 2
        stall = 1'b1; consume = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_pc", 32'(pc), 32'h1);
            chk("t4_hold_ir0", 32'(ir0), 32'h2112);
        end
        stall = 1'b0;
        tick(); consume = 2'd0;
        chk("t4_rel_pc", 32'(pc), 32'h3);
        chk("t4_rel_ir0", 32'(ir0), 32'h2334);
        chk("t4_rel_ir1", 32'(ir1), 32'h2256);

        // 5: branch during stall
        stall = 1'b1; br_valid = 1'b1; br_target = 15'h13;
        tick(); stall = 1'b0; br_valid = 1'b0;
`ifndef BR_ZERO_BUBBLE_EN
        chk("t5_bubble", 32'(ir0_valid), 32'h0);
        tick();
`endif
        chk("t5_valid", 32'(ir0_valid), 32'h1);
        chk("t5_pc", 32'(pc), 32'h13);
        chk("t5_ir0", 32'(ir0), 32'h7407);
        chk("t5_ir1", 32'(ir1), 32'h7B01);

        // 6: wrap at top of memory
        br_target = 15'h7FFF; br_valid = 1'b1;
        tick(); br_valid = 1'b0;
        wait_valid("t6_land");
        chk("t6_pc", 32'(pc), 32'h7FFF);
        chk("t6_rom_addr", 32'(rom_addr), 32'h3FFF);
        chk("t6_pc_1", 32'(pc_1), 32'h1);
        chk("t6_ir0", 32'(ir0), 32'h1234);
        chk("t6_ir1", 32'(ir1), 32'h2000);
        consume = 2'd1;
        tick(); consume = 2'd0;
        chk("t6_wrap_pc", 32'(pc), 32'h0);
        chk("t6_wrap_ir0", 32'(ir0), 32'h2000);

        // branch replaced while refilling, then consume=3 acts as 2
        br_target = 15'h100; br_valid = 1'b1; tick();
        br_target = 15'h200; tick();
        br_valid = 1'b0;
        wait_valid("br_replace_land");
        chk("br_replace_pc", 32'(pc), 32'h200);
        consume = 2'd3;
        tick(); consume = 2'd0;
        chk("consume3_pc", 32'(pc), 32'h202);

        // asynchronous reset mid-run
        consume = 2'd2;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_valid", 32'(ir0_valid), 32'h0);
        chk("arst_ir0", 32'(ir0), 32'h0);
        consume = 2'd0;
        tick(); rst_n = 1'b1;
        tick();
        chk("refill_pc", 32'(pc), 32'h0);
        chk("refill_ir0", 32'(ir0), 32'h2000);

        // mixed traffic, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            consume   = 2'($urandom_range(0, 3));
            br_valid  = ($urandom_range(0, 7) == 0);
            br_target = 15'($urandom);
            tick();
        end
        stall = 1'b0; consume = 2'd0; br_valid = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
